reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/cpu_pkg.sv | 5 +
 rtl/reg_scoreboard.sv | 92 +++++++++
 tb/tb_reg_scoreboard.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: register address width and long-op outstanding limit.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_OUT    = 2;
endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks destinations of in-flight long-latency ops and
// stalls ID on RAW/WAW hazards or when the outstanding-op budget is exhausted.
module reg_scoreboard #(
  parameter int NREG    = 32,
  parameter int MAX_OUT = cpu_pkg::MAX_OUT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] id_rs,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] id_rt,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] id_wa,
  input  logic                           id_regwrite,
  input  logic                           id_long,
  input  logic                           ex_advance,
  input  logic                           flush,
  input  logic                           cpl_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] cpl_wa,
  output logic                           stall,
  output logic                           rs_busy,
  output logic                           rt_busy,
  output logic [1:0]                     out_cnt,
  output logic                           err
);

  localparam logic [1:0] CNT_MAX = 2'(MAX_OUT);

  logic [NREG-1:0] r_busy;
  logic [1:0]      r_out_cnt;
  logic            r_err;

  logic [NREG-1:0] w_busy_nxt;
  logic [1:0]      w_cnt_nxt;
  logic            w_rs_busy;
  logic            w_rt_busy;
  logic            w_waw;
  logic            w_full;
  logic            w_stall;
  logic            w_issue;
  logic            w_set;
  logic            w_inc;
  logic            w_cpl_err;

  // A completion in the current cycle bypasses the busy bit it is about to clear.
  assign w_rs_busy = !rst && r_busy[id_rs] && !(cpl_valid && cpl_wa == id_rs) && (id_rs != '0);
  assign w_rt_busy = !rst && r_busy[id_rt] && !(cpl_valid && cpl_wa == id_rt) && (id_rt != '0);
  assign w_waw     = id_regwrite && (id_wa != '0) && r_busy[id_wa] && !(cpl_valid && cpl_wa == id_wa);
  assign w_full    = id_long && (r_out_cnt == CNT_MAX) && !cpl_valid;
  assign w_stall   = !rst && id_valid && !flush && (w_rs_busy || w_rt_busy || w_waw || w_full);

  assign w_issue   = id_valid && ex_advance && !w_stall && !flush;
  assign w_inc     = w_issue && id_long;
  assign w_set     = w_inc && id_regwrite && (id_wa != '0);

  // Destination-less long ops complete with cpl_wa=0, so only the counter is checked then.
  assign w_cpl_err = cpl_valid && (((cpl_wa != '0) && !r_busy[cpl_wa]) || (r_out_cnt == 2'd0));

  always_comb begin
    w_busy_nxt = r_busy;
    if (cpl_valid) w_busy_nxt[cpl_wa] = 1'b0;
    if (w_set)     w_busy_nxt[id_wa]  = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = r_out_cnt;
    case ({w_inc, cpl_valid})
      2'b10:   if (r_out_cnt != CNT_MAX) w_cnt_nxt = r_out_cnt + 2'd1;
      2'b01:   if (r_out_cnt != 2'd0)    w_cnt_nxt = r_out_cnt - 2'd1;
      default: w_cnt_nxt = r_out_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_out_cnt <= 2'd0;
      r_err     <= 1'b0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_out_cnt <= w_cnt_nxt;
      r_err     <= r_err || w_cpl_err;
    end
  end

  assign stall   = w_stall;
  assign rs_busy = w_rs_busy;
  assign rt_busy = w_rt_busy;
  assign out_cnt = r_out_cnt;
  assign err     = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, bypass, counter limits, err and reset.
module tb_reg_scoreboard;
  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_regwrite, id_long, ex_advance, flush, cpl_valid;
  logic [4:0] id_rs, id_rt, id_wa, cpl_wa;
  logic       stall, rs_busy, rt_busy, err;
  logic [1:0] out_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NREG(32), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_wa(id_wa),
    .id_regwrite(id_regwrite), .id_long(id_long),
    .ex_advance(ex_advance), .flush(flush),
    .cpl_valid(cpl_valid), .cpl_wa(cpl_wa),
    .stall(stall), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .out_cnt(out_cnt), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_regwrite = 0; id_long = 0; ex_advance = 0; flush = 0;
    cpl_valid = 0; id_rs = 0; id_rt = 0; id_wa = 0; cpl_wa = 0;
    #1;
  endtask

  task automatic id_op(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                       input logic lng, input logic adv);
    id_valid = 1; id_rs = rs; id_rt = rt; id_wa = wa;
    id_regwrite = 1; id_long = lng; ex_advance = adv;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; #3; rst = 0;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    id_op(5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
    n_total++; if (rs_busy !== 1'b0 || rt_busy !== 1'b0) $display("FAIL reset_busy got=%b%b exp=00", rs_busy, rt_busy); else n_pass++;
    n_total++; if (out_cnt !== 2'd0) $display("FAIL reset_cnt got=%0d exp=0", out_cnt); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    tick();
    n_total++; if (out_cnt !== 2'd0) $display("FAIL reset_hold_cnt got=%0d exp=0", out_cnt); else n_pass++;
    idle();
    rst = 0;
    tick();
  endtask

  task automatic test_raw_bypass();
    id_op(5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    n_total++; if (stall !== 1'b0) $display("FAIL raw_issue_stall got=%b exp=0", stall); else n_pass++;
    tick();
    n_total++; if (out_cnt !== 2'd1) $display("FAIL raw_cnt1 got=%0d exp=1", out_cnt); else n_pass++;
    id_op(5'd5, 5'd2, 5'd6, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (stall !== 1'b1 || rs_busy !== 1'b1 || rt_busy !== 1'b0)
        $display("FAIL raw_hold%0d got stall=%b rs=%b rt=%b exp 1 1 0", i, stall, rs_busy, rt_busy); else n_pass++;
      tick();
    end
    cpl_valid = 1; cpl_wa = 5'd5; #1;
    n_total++; if (stall !== 1'b0 || rs_busy !== 1'b0) $display("FAIL raw_bypass got stall=%b rs=%b exp 0 0", stall, rs_busy); else n_pass++;
    tick();
    idle();
    n_total++; if (out_cnt !== 2'd0 || err !== 1'b0) $display("FAIL raw_done got cnt=%0d err=%b exp 0 0", out_cnt, err); else n_pass++;
    id_op(5'd5, 5'd0, 5'd6, 1'b0, 1'b0);
    n_total++; if (rs_busy !== 1'b0) $display("FAIL raw_cleared got=%b exp=0", rs_busy); else n_pass++;
    idle();
  endtask

  task automatic test_full();
    id_op(5'd0, 5'd0, 5'd3, 1'b1, 1'b1); tick();
    id_op(5'd0, 5'd0, 5'd4, 1'b1, 1'b1); tick();
    n_total++; if (out_cnt !== 2'd2) $display("FAIL full_cnt2 got=%0d exp=2", out_cnt); else n_pass++;
    id_op(5'd1, 5'd2, 5'd8, 1'b1, 1'b1);
    n_total++; if (stall !== 1'b1) $display("FAIL full_stall got=%b exp=1", stall); else n_pass++;
    tick();
    n_total++; if (out_cnt !== 2'd2) $display("FAIL full_no_issue got=%0d exp=2", out_cnt); else n_pass++;
    cpl_valid = 1; cpl_wa = 5'd3; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL full_cpl_stall got=%b exp=0", stall); else n_pass++;
    tick();
    idle();
    n_total++; if (out_cnt !== 2'd2 || err !== 1'b0) $display("FAIL full_swap got cnt=%0d err=%b exp 2 0", out_cnt, err); else n_pass++;
    id_op(5'd3, 5'd8, 5'd0, 1'b0, 1'b0);
    n_total++; if (rs_busy !== 1'b0 || rt_busy !== 1'b1) $display("FAIL full_busy_map got rs=%b rt=%b exp 0 1", rs_busy, rt_busy); else n_pass++;
    idle();
    cpl_valid = 1; cpl_wa = 5'd4; tick();
    cpl_wa = 5'd8; tick();
    idle();
    n_total++; if (out_cnt !== 2'd0 || err !== 1'b0) $display("FAIL full_drain got cnt=%0d err=%b exp 0 0", out_cnt, err); else n_pass++;
  endtask

  task automatic test_set_wins();
    id_op(5'd0, 5'd0, 5'd7, 1'b1, 1'b1); tick();
    id_op(5'd1, 5'd2, 5'd7, 1'b0, 1'b1);
    n_total++; if (stall !== 1'b1) $display("FAIL waw_stall got=%b exp=1", stall); else n_pass++;
    id_op(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    cpl_valid = 1; cpl_wa = 5'd7; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL setwin_stall got=%b exp=0", stall); else n_pass++;
    tick();
    idle();
    n_total++; if (out_cnt !== 2'd1) $display("FAIL setwin_cnt got=%0d exp=1", out_cnt); else n_pass++;
    id_op(5'd7, 5'd0, 5'd9, 1'b0, 1'b0);
    n_total++; if (rs_busy !== 1'b1 || stall !== 1'b1) $display("FAIL setwin_busy got rs=%b stall=%b exp 1 1", rs_busy, stall); else n_pass++;
    idle();
    cpl_valid = 1; cpl_wa = 5'd7; tick();
    idle();
    n_total++; if (out_cnt !== 2'd0 || err !== 1'b0) $display("FAIL setwin_drain got cnt=%0d err=%b exp 0 0", out_cnt, err); else n_pass++;
  endtask

  task automatic test_zero_reg();
    id_op(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); tick();
    n_total++; if (out_cnt !== 2'd1) $display("FAIL zero_cnt got=%0d exp=1", out_cnt); else n_pass++;
    id_op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    n_total++; if (rs_busy !== 1'b0 || stall !== 1'b0) $display("FAIL zero_busy got rs=%b stall=%b exp 0 0", rs_busy, stall); else n_pass++;
    idle();
    cpl_valid = 1; cpl_wa = 5'd0; tick();
    idle();
    n_total++; if (err !== 1'b0 || out_cnt !== 2'd0) $display("FAIL zero_cpl got err=%b cnt=%0d exp 0 0", err, out_cnt); else n_pass++;
  endtask

  task automatic test_flush_and_idle();
    id_op(5'd0, 5'd0, 5'd11, 1'b1, 1'b1); tick();
    id_op(5'd11, 5'd0, 5'd12, 1'b1, 1'b1);
    flush = 1; #1;
    n_total++; if (stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall); else n_pass++;
    tick();
    n_total++; if (out_cnt !== 2'd1) $display("FAIL flush_cnt got=%0d exp=1", out_cnt); else n_pass++;
    flush = 0; id_valid = 0; #1;
    n_total++; if (stall !== 1'b0 || rs_busy !== 1'b1) $display("FAIL idle_hazard got stall=%b rs=%b exp 0 1", stall, rs_busy); else n_pass++;
    tick();
    id_op(5'd12, 5'd0, 5'd0, 1'b0, 1'b0);
    n_total++; if (rs_busy !== 1'b0) $display("FAIL flush_no_set got=%b exp=0", rs_busy); else n_pass++;
    idle();
    cpl_valid = 1; cpl_wa = 5'd11; tick();
    idle();
    n_total++; if (out_cnt !== 2'd0 || err !== 1'b0) $display("FAIL flush_drain got cnt=%0d err=%b exp 0 0", out_cnt, err); else n_pass++;
  endtask

  task automatic test_err_sticky();
    cpl_valid = 1; cpl_wa = 5'd9; #1;
    n_total++; if (err !== 1'b0) $display("FAIL err_pre got=%b exp=0", err); else n_pass++;
    tick();
    idle();
    n_total++; if (err !== 1'b1 || out_cnt !== 2'd0) $display("FAIL err_set got err=%b cnt=%0d exp 1 0", err, out_cnt); else n_pass++;
    repeat (3) tick();
    n_total++; if (err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", err); else n_pass++;
    rst = 1; #1;
    n_total++; if (err !== 1'b0) $display("FAIL err_rst got=%b exp=0", err); else n_pass++;
    rst = 0;
    tick();
  endtask

  task automatic test_async_reset();
    id_op(5'd0, 5'd0, 5'd2, 1'b1, 1'b1); tick();
    id_op(5'd2, 5'd0, 5'd3, 1'b0, 1'b0);
    n_total++; if (stall !== 1'b1 || out_cnt !== 2'd1) $display("FAIL arst_pre got stall=%b cnt=%0d exp 1 1", stall, out_cnt); else n_pass++;
    #2 rst = 1; #1;
    n_total++; if (stall !== 1'b0 || rs_busy !== 1'b0 || out_cnt !== 2'd0)
      $display("FAIL arst_now got stall=%b rs=%b cnt=%0d exp 0 0 0", stall, rs_busy, out_cnt); else n_pass++;
    rst = 0; #1;
    n_total++; if (stall !== 1'b0 || rs_busy !== 1'b0) $display("FAIL arst_after got stall=%b rs=%b exp 0 0", stall, rs_busy); else n_pass++;
    idle();
    cpl_valid = 1; cpl_wa = 5'd2; tick();
    idle();
    n_total++; if (err !== 1'b1 || out_cnt !== 2'd0) $display("FAIL arst_late_cpl got err=%b cnt=%0d exp 1 0", err, out_cnt); else n_pass++;
    do_reset();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_raw_bypass();
    test_full();
    test_set_wins();
    test_zero_reg();
    test_flush_and_idle();
    test_err_sticky();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
